inst_fetch_resp: RTL and testbench
==================================

# inst_fetch_resp

Responder side of the PC-generator fetch request. Accepts a fetch request carrying an instruction-address pair plus PC exception status, reads one or two 32-bit instructions over a single-outstanding SRAM-like instruction bus, and presents the pair to the decode stage with a valid/ready handshake. Back-pressures the PC stage through `stall` and discards in-flight work on `flush`.

## Interface
Parameters:
- `RESET_ADDR`, default 32'h0000_0000: reset value of `mem_addr`.

Ports (all outputs registered except `stall`):
- `clk` in 1: single clock; everything samples on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst_rreq` in 1: fetch request valid from the PC stage.
- `pc1` in 32: first fetch address.
- `pc2` in 32: second fetch address.
- `pc_is_exception` in 1: `pc1` is faulty (ADEF).
- `pc_exception_cause` in 7: cause code passed through with the request.
- `flush` in 1: back-end redirect; kill the current request.
- `stall` out 1: combinational; 1 whenever state != IDLE.
- `mem_req` out 1: bus read request.
- `mem_addr` out 32: bus read address.
- `mem_addr_ok` in 1: request accepted this cycle.
- `mem_data_ok` in 1: read data valid this cycle. Arrives at least 1 cycle after its `mem_addr_ok`.
- `mem_rdata` in 32: read data.
- `out_valid` out 1: instruction pair valid to decode.
- `out_ready` in 1: decode accepts the pair.
- `out_pc1` out 32, `out_inst1` out 32: first slot.
- `out_valid2` out 1, `out_pc2` out 32, `out_inst2` out 32: second slot.
- `out_is_exception` out 1, `out_exception_cause` out 7: slot-1 exception.

## Operation
- FSM states: IDLE, RD1, WT1, RD2, WT2, OUT, DRAIN.
- IDLE:
  - Accept when `inst_rreq & !flush`. Latch `pc1`, `pc2`, exception and cause.
  - Non-exception request -> RD1.
  - Exception request -> OUT with `out_inst1`=0, `out_valid2`=0, and no bus access.
- RD1: `mem_req`=1, `mem_addr`=pc1. Hold until `mem_addr_ok`, then -> WT1.
- WT1: on `mem_data_ok`, capture `inst1`, then -> RD2.
- RD2: `mem_req`=1, `mem_addr`=pc2. Hold until `mem_addr_ok`, then -> WT2.
- WT2: on `mem_data_ok`, capture `inst2`, then -> OUT.
- OUT: `out_valid`=1. On `out_ready`, -> IDLE. Outputs stay stable while `out_ready`=0.
- Flush behaviour:
  - IDLE or OUT: drop, -> IDLE. `out_valid` falls next cycle.
  - RD1 or RD2: keep `mem_req` with the same address until `mem_addr_ok`, then -> DRAIN. A bus request is never retracted.
  - WT1 or WT2: -> DRAIN, unless `mem_data_ok` arrives in the same cycle, in which case -> IDLE with the data discarded.
  - DRAIN: wait for `mem_data_ok`, discard the data, -> IDLE. Further flushes in DRAIN are ignored.
- Only one bus transaction is outstanding at any time.
- `out_exception_cause` is the latched cause, NOP when there is no exception.

## Timing
- Reset values: state=IDLE, `stall`=0, `mem_req`=0, `mem_addr`=RESET_ADDR, `out_valid`=0, `out_valid2`=0, all out data/pc/exception fields 0.
- Reset asserted mid-transaction returns to IDLE immediately; late `mem_data_ok` pulses after reset are ignored in IDLE.
- Best-case latency, with acceptance at cycle T and zero-wait bus:
  - RD1 at T+1, `data_ok` at T+2.
  - RD2 at T+3, `data_ok` at T+4.
  - `out_valid` at T+5.
- Exception request: `out_valid` at T+1.
- `stall` goes 1 in the cycle after acceptance and returns to 0 in the cycle after the OUT handshake or after the DRAIN/flush exit.
- When `flush` and `inst_rreq` are both high in IDLE, the request is not accepted.

## Configuration
- `FETCH_DUAL_EN` defined:
  - Behaviour as above.
  - `out_valid2`=1 for every non-exception pair.
- `FETCH_DUAL_EN` undefined:
  - RD2 and WT2 do not exist; WT1 `data_ok` -> OUT.
  - `out_valid2`=0, `out_inst2`=0, `out_pc2`=latched pc2.
  - Best-case latency is T+3.

## Test plan
- Zero-wait fetch, `pc1`=1c000000, `pc2`=1c000004, mem returns 02800000 and 02800401 -> `mem_addr` sequence 1c000000 then 1c000004; `out_valid` at T+5 with those instructions; `stall` high T+1..T+5.
- `out_ready` held low for 3 cycles in OUT -> all outputs stable; `stall`=1; IDLE the cycle after `out_ready`=1.
- `pc_is_exception`=1 with cause ADEF and `pc1`=1c000002 -> no `mem_req`; `out_valid` at T+1 with `out_is_exception`=1, ADEF cause, `out_valid2`=0.
- `flush` in RD1 while `mem_addr_ok`=0 for 2 cycles -> `mem_req` held at pc1 until `addr_ok`; DRAIN swallows the `data_ok`; `out_valid` never rises; `stall` 0 after `data_ok`+1.
- `flush` coinciding with WT2 `mem_data_ok` -> next state IDLE, no `out_valid`.
- Build without `FETCH_DUAL_EN` -> a single bus access; `out_valid` at T+3; `out_valid2`=0.

Source files
------------

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp
// Responder for the PC-stage fetch request. Reads one or two instructions over
// a single-outstanding SRAM-like bus and hands the pair to decode.
// Build option: FETCH_DUAL_EN -- when defined, both pc1 and pc2 are fetched and
// out_valid2 is raised for every non-exception pair; when undefined only pc1 is
// read, out_inst2 stays 0 and out_pc2 carries the latched pc2.
//
// Handshakes: out_valid/out_ready is a strict valid/ready pair -- once out_valid
// is high every out_* field holds until the cycle out_ready is sampled high; a
// pair transfers on a rising edge where both are high. On the bus, mem_req holds
// with a fixed mem_addr until mem_addr_ok, and a request is never withdrawn.
module inst_fetch_resp #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_rreq,
   input  logic [31:0] pc1,
   input  logic [31:0] pc2,
   input  logic        pc_is_exception,
   input  logic [6:0]  pc_exception_cause,
   input  logic        flush,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc1,
   output logic [31:0] out_inst1,
   output logic        out_valid2,
   output logic [31:0] out_pc2,
   output logic [31:0] out_inst2,
   output logic        out_is_exception,
   output logic [6:0]  out_exception_cause
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD1   = 3'd1,
      WT1   = 3'd2,
      RD2   = 3'd3,
      WT2   = 3'd4,
      OUT   = 3'd5,
      DRAIN = 3'd6
   } state_t;

   state_t state;
   // A flush seen while a read request is still waiting for mem_addr_ok
   logic   flush_pend;

   // Back-pressure the PC stage whenever a request is being worked on
   assign stall = (state != IDLE);

   // Fetch FSM with registered bus and decode-side outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         flush_pend          <= 1'b0;
         mem_req             <= 1'b0;
         mem_addr            <= RESET_ADDR;
         out_valid           <= 1'b0;
         out_valid2          <= 1'b0;
         out_pc1             <= 32'd0;
         out_inst1           <= 32'd0;
         out_pc2             <= 32'd0;
         out_inst2           <= 32'd0;
         out_is_exception    <= 1'b0;
         out_exception_cause <= 7'd0;
      end else begin
         case (state)
            IDLE: begin
               if (inst_rreq && !flush) begin
                  out_pc1             <= pc1;
                  out_pc2             <= pc2;
                  out_inst1           <= 32'd0;
                  out_inst2           <= 32'd0;
                  out_is_exception    <= pc_is_exception;
                  out_exception_cause <= pc_is_exception ? pc_exception_cause : 7'd0;
                  flush_pend          <= 1'b0;
                  if (pc_is_exception) begin
                     // Faulty pc1: nothing to fetch, present the exception at once
                     state      <= OUT;
                     out_valid  <= 1'b1;
                     out_valid2 <= 1'b0;
                  end else begin
                     state    <= RD1;
                     mem_req  <= 1'b1;
                     mem_addr <= pc1;
                  end
               end
            end
            RD1: begin
               if (flush) flush_pend <= 1'b1;
               if (mem_addr_ok) begin
                  mem_req <= 1'b0;
                  state   <= (flush || flush_pend) ? DRAIN : WT1;
               end
            end
            WT1: begin
               if (flush) begin
                  // Data arriving with the flush is simply dropped
                  state <= mem_data_ok ? IDLE : DRAIN;
               end else if (mem_data_ok) begin
                  out_inst1 <= mem_rdata;
`ifdef FETCH_DUAL_EN
                  state      <= RD2;
                  mem_req    <= 1'b1;
                  mem_addr   <= out_pc2;
                  flush_pend <= 1'b0;
`else
                  state      <= OUT;
                  out_valid  <= 1'b1;
                  out_valid2 <= 1'b0;
`endif
               end
            end
`ifdef FETCH_DUAL_EN
            RD2: begin
               if (flush) flush_pend <= 1'b1;
               if (mem_addr_ok) begin
                  mem_req <= 1'b0;
                  state   <= (flush || flush_pend) ? DRAIN : WT2;
               end
            end
            WT2: begin
               if (flush) begin
                  state <= mem_data_ok ? IDLE : DRAIN;
               end else if (mem_data_ok) begin
                  out_inst2  <= mem_rdata;
                  state      <= OUT;
                  out_valid  <= 1'b1;
                  out_valid2 <= 1'b1;
               end
            end
`endif
            OUT: begin
               if (out_ready || flush) begin
                  state      <= IDLE;
                  out_valid  <= 1'b0;
                  out_valid2 <= 1'b0;
               end
            end
            DRAIN: begin
               // Swallow the read still owed by the bus; flushes change nothing here
               if (mem_data_ok) state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// tb_inst_fetch_resp
// Directed latency/flush/reset scenarios followed by randomized fetches.
// Expected pairs come from a reference model built on a memory map; a monitor
// compares every cycle the DUT presents a pair. Define FETCH_DUAL_EN to match
// the DUT build.
module tb_inst_fetch_resp;

`ifdef FETCH_DUAL_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif
   localparam logic [31:0] RST_ADDR = 32'h1bff_fff0;
   localparam logic [6:0]  ADEF     = 7'h08;
   localparam int          EW       = 137;

   typedef struct packed {
      logic [31:0] pc1;
      logic [31:0] pc2;
      logic [31:0] inst1;
      logic [31:0] inst2;
      logic        v2;
      logic        exc;
      logic [6:0]  cause;
   } exp_t;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        inst_rreq, pc_is_exception, flush, out_ready;
   logic [31:0] pc1, pc2;
   logic [6:0]  pc_exception_cause;
   logic        stall, mem_req, mem_addr_ok, mem_data_ok;
   logic [31:0] mem_addr, mem_rdata;
   logic        out_valid, out_valid2, out_is_exception;
   logic [31:0] out_pc1, out_inst1, out_pc2, out_inst2;
   logic [6:0]  out_exception_cause;

   initial forever #5 clk = ~clk;

   inst_fetch_resp #(.RESET_ADDR(RST_ADDR)) dut (
      .clk(clk), .rst(rst), .inst_rreq(inst_rreq), .pc1(pc1), .pc2(pc2),
      .pc_is_exception(pc_is_exception), .pc_exception_cause(pc_exception_cause),
      .flush(flush), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc1(out_pc1),
      .out_inst1(out_inst1), .out_valid2(out_valid2), .out_pc2(out_pc2),
      .out_inst2(out_inst2), .out_is_exception(out_is_exception),
      .out_exception_cause(out_exception_cause)
   );

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [EW-1:0] exp_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] mem_arr [logic [31:0]];

   int unsigned ok_pct, dmin, dmax;
   bit          rand_ready, ready_fixed;
   bit          pend;
   int          pend_cnt;
   logic [31:0] pend_addr;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Instruction memory seen by the bus; unmapped words follow a fixed hash
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return {a[15:0], a[31:16]} ^ 32'h0280_0000;
   endfunction

   // Reference model: what decode must see for an accepted request
   function automatic exp_t model(input logic [31:0] a1, input logic [31:0] a2,
                                  input logic e, input logic [6:0] c);
      exp_t r;
      r.pc1   = a1;
      r.pc2   = a2;
      r.exc   = e;
      r.cause = e ? c : 7'd0;
      r.inst1 = e ? 32'd0 : mem_word(a1);
      r.v2    = !e && DUAL;
      r.inst2 = (!e && DUAL) ? mem_word(a2) : 32'd0;
      return r;
   endfunction

   // ---------------- bus responder ----------------
   initial begin
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
      pend = 1'b0; pend_cnt = 0; pend_addr = 32'd0;
      forever begin
         @(posedge clk); #1;
         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b0;
         mem_rdata   = $urandom;
         if (pend) begin
            if (rst === 1'b1) check32("mem_req_while_outstanding", {31'd0, mem_req}, 32'd0);
            if (pend_cnt == 0) begin
               mem_data_ok = 1'b1;
               mem_rdata   = mem_word(pend_addr);
               pend        = 1'b0;
            end else begin
               pend_cnt--;
            end
         end else if (mem_req === 1'b1 && $urandom_range(99) < ok_pct) begin
            mem_addr_ok = 1'b1;
            pend        = 1'b1;
            pend_addr   = mem_addr;
            pend_cnt    = $urandom_range(dmax, dmin);
            if (addr_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL mem_req_unexpected: got request to %h required none", mem_addr);
            end else begin
               check32("mem_addr", mem_addr, addr_q.pop_front());
            end
         end
      end
   end

   // ---------------- out_ready driver ----------------
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         out_ready = rand_ready ? 1'($urandom_range(1)) : ready_fixed;
      end
   end

   // ---------------- monitor ----------------
   initial begin
      exp_t m;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && out_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL out_valid_unexpected: got out_valid=%b required 0", out_valid);
            end else begin
               m = exp_q[0];
               check32("out_pc1", out_pc1, m.pc1);
               check32("out_inst1", out_inst1, m.inst1);
               check32("out_valid2", {31'd0, out_valid2}, {31'd0, m.v2});
               check32("out_pc2", out_pc2, m.pc2);
               check32("out_inst2", out_inst2, m.inst2);
               check32("out_is_exception", {31'd0, out_is_exception}, {31'd0, m.exc});
               check32("out_exception_cause", {25'd0, out_exception_cause}, {25'd0, m.cause});
               if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while (stall !== 1'b0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) check32("wait_idle_timeout", {31'd0, stall}, 32'd0);
   endtask

   // Present one request for a single cycle; returns one step into the cycle after acceptance
   task automatic issue(input logic [31:0] a1, input logic [31:0] a2, input logic e,
                        input logic [6:0] c, input bit track);
      wait_idle();
      @(posedge clk); #1;
      inst_rreq = 1'b1; pc1 = a1; pc2 = a2; pc_is_exception = e; pc_exception_cause = c;
      if (track) begin
         exp_q.push_back(model(a1, a2, e, c));
         if (!e) begin
            addr_q.push_back(a1);
            if (DUAL) addr_q.push_back(a2);
         end
      end
      @(posedge clk); #1;
      inst_rreq = 1'b0; pc1 = $urandom; pc2 = $urandom;
      pc_is_exception = 1'($urandom_range(1)); pc_exception_cause = 7'($urandom);
   endtask

   task automatic wait_valid(input int exp_lat);
      int cyc = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         check32("stall_busy", {31'd0, stall}, 32'd1);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      check32("out_valid_latency", cyc, exp_lat);
   endtask

   task automatic drain_wait();
      int cyc = 0;
      bit got = 1'b0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         check32("stall_drain", {31'd0, stall}, 32'd1);
         if (mem_data_ok === 1'b1) got = 1'b1;
      end
      check32("drain_data_seen", {31'd0, got}, 32'd1);
      @(negedge clk);
      check32("stall_after_drain", {31'd0, stall}, 32'd0);
      check32("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a1;
      logic        e;
      rst = 1'b0;
      inst_rreq = 1'b0; pc1 = 32'd0; pc2 = 32'd0; pc_is_exception = 1'b0;
      pc_exception_cause = 7'd0; flush = 1'b0;
      ready_fixed = 1'b1; rand_ready = 1'b0; ok_pct = 100; dmin = 0; dmax = 0;
      mem_arr[32'h1c00_0000] = 32'h0280_0000;
      mem_arr[32'h1c00_0004] = 32'h0280_0401;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check32("rst_stall", {31'd0, stall}, 32'd0);
      check32("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check32("rst_mem_addr", mem_addr, RST_ADDR);
      check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check32("rst_out_valid2", {31'd0, out_valid2}, 32'd0);
      check32("rst_out_pc1", out_pc1, 32'd0);
      check32("rst_out_inst1", out_inst1, 32'd0);
      check32("rst_out_pc2", out_pc2, 32'd0);
      check32("rst_out_inst2", out_inst2, 32'd0);
      check32("rst_out_exc", {31'd0, out_is_exception}, 32'd0);
      check32("rst_out_cause", {25'd0, out_exception_cause}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // zero-wait fetch
      issue(32'h1c00_0000, 32'h1c00_0004, 1'b0, 7'h15, 1'b1);
      wait_valid(DUAL ? 5 : 3);
      @(negedge clk);
      check32("stall_after_handshake", {31'd0, stall}, 32'd0);

      // decode back-pressure for 3 cycles
      ready_fixed = 1'b0;
      issue(32'h1c00_0010, 32'h1c00_0014, 1'b0, 7'h00, 1'b1);
      wait_valid(DUAL ? 5 : 3);
      @(negedge clk);
      check32("hold_stall", {31'd0, stall}, 32'd1);
      check32("hold_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      check32("hold_stall", {31'd0, stall}, 32'd1);
      check32("hold_valid", {31'd0, out_valid}, 32'd1);
      ready_fixed = 1'b1;
      @(negedge clk);
      check32("hold_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      check32("idle_after_ready", {31'd0, stall}, 32'd0);
      check32("valid_after_ready", {31'd0, out_valid}, 32'd0);

      // exception request: no bus access
      issue(32'h1c00_0002, 32'h1c00_0006, 1'b1, ADEF, 1'b1);
      wait_valid(1);
      @(negedge clk);
      check32("exc_idle", {31'd0, stall}, 32'd0);

      // flush in RD1 while the bus withholds mem_addr_ok for 2 cycles
      ok_pct = 0; dmin = 0; dmax = 2;
      addr_q.push_back(32'h1c00_0100);
      issue(32'h1c00_0100, 32'h1c00_0104, 1'b0, 7'h00, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      check32("rd1_flush_req", {31'd0, mem_req}, 32'd1);
      check32("rd1_flush_addr", mem_addr, 32'h1c00_0100);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check32("rd1_flush_req_held", {31'd0, mem_req}, 32'd1);
      check32("rd1_flush_addr_held", mem_addr, 32'h1c00_0100);
      ok_pct = 100;
      drain_wait();

      // flush in WT1 before data -> DRAIN
      dmin = 2; dmax = 2;
      addr_q.push_back(32'h1c00_0200);
      issue(32'h1c00_0200, 32'h1c00_0204, 1'b0, 7'h00, 1'b0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      drain_wait();

      // flush coinciding with the final mem_data_ok
      dmin = 0; dmax = 0;
      addr_q.push_back(32'h1c00_0300);
      if (DUAL) addr_q.push_back(32'h1c00_0304);
      issue(32'h1c00_0300, 32'h1c00_0304, 1'b0, 7'h00, 1'b0);
      repeat (DUAL ? 3 : 1) @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      check32("last_data_flush_stall", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check32("last_data_flush_idle", {31'd0, stall}, 32'd0);
      check32("last_data_flush_valid", {31'd0, out_valid}, 32'd0);

      // flush while presenting the pair
      ready_fixed = 1'b0;
      issue(32'h1c00_0400, 32'h1c00_0404, 1'b0, 7'h00, 1'b1);
      wait_valid(DUAL ? 5 : 3);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check32("out_flush_valid", {31'd0, out_valid}, 32'd0);
      check32("out_flush_stall", {31'd0, stall}, 32'd0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      ready_fixed = 1'b1;

      // request and flush together in IDLE: not accepted
      wait_idle();
      @(posedge clk); #1;
      inst_rreq = 1'b1; flush = 1'b1; pc1 = 32'h1c00_0500; pc_is_exception = 1'b0;
      @(posedge clk); #1;
      inst_rreq = 1'b0; flush = 1'b0;
      @(negedge clk);
      check32("rreq_flush_stall", {31'd0, stall}, 32'd0);
      check32("rreq_flush_req", {31'd0, mem_req}, 32'd0);

      // reset during WT1 with a late mem_data_ok afterwards
      dmin = 3; dmax = 3;
      addr_q.push_back(32'h1c00_0600);
      issue(32'h1c00_0600, 32'h1c00_0604, 1'b0, 7'h00, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check32("async_rst_stall", {31'd0, stall}, 32'd0);
      check32("async_rst_req", {31'd0, mem_req}, 32'd0);
      check32("async_rst_addr", mem_addr, RST_ADDR);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check32("late_data_stall", {31'd0, stall}, 32'd0);
      end

      // randomized fetches against the reference model
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ok_pct = $urandom_range(100, 30);
         dmin = 0;
         dmax = $urandom_range(3, 0);
         e  = ($urandom_range(4) == 0);
         a1 = {$urandom} & 32'hffff_fffc;
         if (e) a1[1:0] = 2'($urandom_range(3, 1));
         issue(a1, a1 + 32'd4, e, 7'($urandom), 1'b1);
         repeat ($urandom_range(2)) @(posedge clk);
      end
      begin
         int guard = 0;
         while ((exp_q.size() != 0 || stall !== 1'b0) && guard < 1000) begin
            @(negedge clk);
            guard++;
         end
      end
      rand_ready = 1'b0;
      check32("exp_q_empty", exp_q.size(), 32'd0);
      check32("addr_q_empty", addr_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Time limit so the run always ends
   initial begin
      #2000000;
      n_cmp++; n_bad++;
      $display("FAIL watchdog: run did not complete within the time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
